// File: rtl/eco_pkg.sv
// Shared types and constants for the ECO equivalence-sweep controller.
package eco_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_APPLY  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int DEF_W      = 3;
  localparam int DEF_SETTLE = 1;

  // Number of {a,b} vectors in one exhaustive sweep.
  function automatic int vec_count(input int w);
    return 1 << (2 * w);
  endfunction

endpackage

// File: rtl/eco_cmp_accum.sv
// Compares the two cone outputs and accumulates mismatch count,
// first failing vector and the OR of all differing bits.
module eco_cmp_accum
  import eco_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int CNT_W = 2 * W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             sample_en,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [W-1:0]     y_ref,
  input  logic [W-1:0]     y_dut,
  output logic [CNT_W-1:0] mism_cnt,
  output logic             first_valid,
  output logic [W-1:0]     first_a,
  output logic [W-1:0]     first_b,
  output logic [W-1:0]     diff_bits
);

  logic [W-1:0] xor_bits;
  logic         mismatch;

  assign xor_bits = y_ref ^ y_dut;
  assign mismatch = |xor_bits;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mism_cnt    <= '0;
      first_valid <= 1'b0;
      first_a     <= '0;
      first_b     <= '0;
      diff_bits   <= '0;
    end else if (clear) begin
      mism_cnt    <= '0;
      first_valid <= 1'b0;
      first_a     <= '0;
      first_b     <= '0;
      diff_bits   <= '0;
    end else if (sample_en && mismatch) begin
      mism_cnt  <= mism_cnt + 1'b1;
      diff_bits <= diff_bits | xor_bits;
      // Only the earliest failing vector is kept.
      if (!first_valid) begin
        first_valid <= 1'b1;
        first_a     <= a;
        first_b     <= b;
      end
    end
  end

endmodule

// File: rtl/eco_sweep_ctrl.sv
// Exhaustive equivalence sweep: walks every {a,b}, waits SETTLE cycles,
// then compares original and patched cone outputs.
module eco_sweep_ctrl
  import eco_pkg::*;
#(
  parameter int W      = DEF_W,
  parameter int SETTLE = DEF_SETTLE,
  parameter int CNT_W  = 2 * W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic [W-1:0]     a_o,
  output logic [W-1:0]     b_o,
  input  logic [W-1:0]     y_ref_i,
  input  logic [W-1:0]     y_dut_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] mism_cnt,
  output logic             first_valid,
  output logic [W-1:0]     first_a,
  output logic [W-1:0]     first_b,
  output logic [W-1:0]     diff_bits
);

  localparam int IDX_W = 2 * W;
  localparam int SET_W = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam logic [SET_W-1:0] SET_LOAD = SET_W'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(vec_count(W) - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [SET_W-1:0] settle_cnt;
  logic             in_sweep;
  logic             clear;
  logic             sample_en;

  assign idx_nxt   = idx + 1'b1;
  assign in_sweep  = (state == ST_APPLY) || (state == ST_WAIT) || (state == ST_SAMPLE);
  assign clear     = (state == ST_IDLE) && start;
  // An aborting cycle's sample is dropped.
  assign sample_en = (state == ST_SAMPLE) && !abort;

  eco_cmp_accum #(.W(W), .CNT_W(CNT_W)) u_accum (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .sample_en   (sample_en),
    .a           (a_o),
    .b           (b_o),
    .y_ref       (y_ref_i),
    .y_dut       (y_dut_i),
    .mism_cnt    (mism_cnt),
    .first_valid (first_valid),
    .first_a     (first_a),
    .first_b     (first_b),
    .diff_bits   (diff_bits)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      a_o        <= '0;
      b_o        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (in_sweep && abort) begin
        state <= ST_IDLE;
        idx   <= '0;
        a_o   <= '0;
        b_o   <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              idx   <= '0;
              a_o   <= '0;
              b_o   <= '0;
              busy  <= 1'b1;
              pass  <= 1'b0;
              state <= ST_APPLY;
            end
          end
          ST_APPLY: begin
            settle_cnt <= SET_LOAD;
            state      <= (SETTLE > 0) ? ST_WAIT : ST_SAMPLE;
          end
          ST_WAIT: begin
            if (settle_cnt == '0) state <= ST_SAMPLE;
            else                  settle_cnt <= settle_cnt - 1'b1;
          end
          ST_SAMPLE: begin
            if (idx == IDX_LAST) begin
              // Operands drop here so every vector holds for SETTLE+2 cycles.
              a_o   <= '0;
              b_o   <= '0;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              idx   <= idx_nxt;
              a_o   <= idx_nxt[IDX_W-1:W];
              b_o   <= idx_nxt[W-1:0];
              state <= ST_APPLY;
            end
          end
          ST_DONE: begin
            done  <= 1'b1;
            pass  <= (mism_cnt == '0);
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eco_sweep_ctrl.sv
// Directed bench for eco_sweep_ctrl: table of whole-sweep scenarios plus
// hand-written abort, busy-start, zero-settle and reset sequences.
module tb_eco_sweep_ctrl;
  import eco_pkg::*;

  localparam int W = 3;
  localparam int CNT_W = 2 * W + 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // SETTLE=1 instance with a faultable patched cone
  logic             start = 1'b0, abort = 1'b0;
  logic [W-1:0]     a_o, b_o, y_ref, y_dut, first_a, first_b, diff_bits;
  logic             busy, done, pass, first_valid;
  logic [CNT_W-1:0] mism_cnt;
  int               mode = 0;

  // SETTLE=0 instance with identical cones
  logic             start0 = 1'b0;
  logic [W-1:0]     a0, b0, y_ref0, first_a0, first_b0, diff_bits0;
  logic             busy0, done0, pass0, first_valid0;
  logic [CNT_W-1:0] mism_cnt0;

  assign y_ref  = a_o + b_o;
  assign y_ref0 = a0 * b0;

  always_comb begin
    y_dut = y_ref;
    case (mode)
      1: if (a_o == 3'd5 && b_o == 3'd3) y_dut = y_ref ^ 3'b010;
      2: y_dut = y_ref ^ 3'b001;
      3: begin
        if (a_o == 3'd1 && b_o == 3'd2) y_dut = y_ref ^ 3'b100;
        if (a_o == 3'd6 && b_o == 3'd7) y_dut = y_ref ^ 3'b001;
      end
      default: y_dut = y_ref;
    endcase
  end

  eco_sweep_ctrl #(.W(W), .SETTLE(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_o(a_o), .b_o(b_o), .y_ref_i(y_ref), .y_dut_i(y_dut),
    .busy(busy), .done(done), .pass(pass), .mism_cnt(mism_cnt),
    .first_valid(first_valid), .first_a(first_a), .first_b(first_b),
    .diff_bits(diff_bits)
  );

  eco_sweep_ctrl #(.W(W), .SETTLE(0), .CNT_W(CNT_W)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(1'b0),
    .a_o(a0), .b_o(b0), .y_ref_i(y_ref0), .y_dut_i(y_ref0),
    .busy(busy0), .done(done0), .pass(pass0), .mism_cnt(mism_cnt0),
    .first_valid(first_valid0), .first_a(first_a0), .first_b(first_b0),
    .diff_bits(diff_bits0)
  );

  // scoreboard
  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int   mode;
    logic with_abort;
    int   exp_cyc;
    int   exp_pass;
    int   exp_cnt;
    int   exp_fv;
    int   exp_fa;
    int   exp_fb;
    int   exp_diff;
  } vec_t;

  vec_t tbl[4];

  // Pulses start on the selected instance and counts cycles from the
  // accepting edge until done is seen; optionally re-pokes start at poke_cyc.
  task automatic run_sweep(input int sel, input logic with_abort,
                           input int poke_cyc, output int cyc);
    @(negedge clk);
    if (sel == 0) start0 = 1'b1;
    else begin
      start = 1'b1;
      abort = with_abort;
    end
    @(posedge clk); #1;
    start0 = 1'b0; start = 1'b0; abort = 1'b0;
    cyc = 0;
    while (!((sel == 0) ? done0 : done) && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      start = (sel == 1 && cyc == poke_cyc);
    end
    start = 1'b0;
    if (cyc >= 400) check("sweep_timeout", cyc, -1);
  endtask

  initial begin
    int cyc;
    tbl[0] = '{mode: 0, with_abort: 1'b0, exp_cyc: 193, exp_pass: 1, exp_cnt: 0,
               exp_fv: 0, exp_fa: 0, exp_fb: 0, exp_diff: 0};
    tbl[1] = '{mode: 1, with_abort: 1'b0, exp_cyc: 193, exp_pass: 0, exp_cnt: 1,
               exp_fv: 1, exp_fa: 5, exp_fb: 3, exp_diff: 2};
    tbl[2] = '{mode: 2, with_abort: 1'b0, exp_cyc: 193, exp_pass: 0, exp_cnt: 64,
               exp_fv: 1, exp_fa: 0, exp_fb: 0, exp_diff: 1};
    tbl[3] = '{mode: 3, with_abort: 1'b1, exp_cyc: 193, exp_pass: 0, exp_cnt: 2,
               exp_fv: 1, exp_fa: 1, exp_fb: 2, exp_diff: 5};

    // reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_a", a_o, 0);
    check("rst_pass", pass, 0);
    check("rst_cnt", mism_cnt, 0);
    @(negedge clk) rst_n = 1'b1;

    // table-driven full sweeps
    for (int i = 0; i < 4; i++) begin
      mode = tbl[i].mode;
      run_sweep(1, tbl[i].with_abort, -1, cyc);
      check($sformatf("t%0d_cycles", i), cyc, tbl[i].exp_cyc);
      check($sformatf("t%0d_pass", i), pass, tbl[i].exp_pass);
      check($sformatf("t%0d_cnt", i), mism_cnt, tbl[i].exp_cnt);
      check($sformatf("t%0d_fv", i), first_valid, tbl[i].exp_fv);
      check($sformatf("t%0d_fa", i), first_a, tbl[i].exp_fa);
      check($sformatf("t%0d_fb", i), first_b, tbl[i].exp_fb);
      check($sformatf("t%0d_diff", i), diff_bits, tbl[i].exp_diff);
      check($sformatf("t%0d_busy", i), busy, 0);
      @(posedge clk); #1;
      check($sformatf("t%0d_done_pulse", i), done, 0);
      check($sformatf("t%0d_pass_hold", i), pass, tbl[i].exp_pass);
    end

    // abort 50 cycles after start, landing on vector 16's sample cycle
    mode = 2;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (50) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_a", a_o, 0);
    check("abort_b", b_o, 0);
    check("abort_cnt", mism_cnt, 16);
    check("abort_diff", diff_bits, 1);
    check("abort_fv", first_valid, 1);
    cyc = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (done) cyc++;
    end
    check("abort_no_done", cyc, 0);
    check("abort_pass", pass, 0);

    // start pulsed while busy is ignored
    mode = 0;
    run_sweep(1, 1'b0, 20, cyc);
    check("busy_start_cycles", cyc, 193);
    check("busy_start_pass", pass, 1);

    // zero settle time
    run_sweep(0, 1'b0, -1, cyc);
    check("s0_cycles", cyc, 129);
    check("s0_pass", pass0, 1);
    check("s0_cnt", mism_cnt0, 0);

    // asynchronous reset mid-sweep
    mode = 2;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("pre_rst_cnt", mism_cnt, 10);
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_a", a_o, 0);
    check("arst_cnt", mism_cnt, 0);
    check("arst_fv", first_valid, 0);
    check("arst_diff", diff_bits, 0);
    check("arst_pass0", pass0, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
